// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment display path (scan mux, decoder, game logic).
package seg_pkg;

    localparam int unsigned BCD_W      = 4;
    localparam int unsigned MAX_DIGITS = 8;

    // Active-low enables: all ones means every digit is dark.
    localparam logic [MAX_DIGITS-1:0] DIG_OFF = '1;
    localparam logic                  DP_OFF  = 1'b1;

    // Non-numeric codes; the scan mux passes them through, the decoder gives them glyphs.
    localparam logic [BCD_W-1:0] CODE_DASH  = 4'd10;
    localparam logic [BCD_W-1:0] CODE_E     = 4'd11;
    localparam logic [BCD_W-1:0] CODE_H     = 4'd12;
    localparam logic [BCD_W-1:0] CODE_L     = 4'd13;
    localparam logic [BCD_W-1:0] CODE_P     = 4'd14;
    localparam logic [BCD_W-1:0] CODE_BLANK = 4'd15;

    typedef enum logic {
        BLINK_ON  = 1'b0,
        BLINK_OFF = 1'b1
    } blink_phase_e;

endpackage

// File: rtl/seg_scan_tick.sv
// Slot prescaler and digit index counter for the display scan.
module seg_scan_tick #(
    parameter int unsigned N_DIGITS = 4,
    parameter int unsigned PRESCALE = 50000,
    localparam int unsigned CNT_W   = $clog2(PRESCALE),
    localparam int unsigned IDX_W   = $clog2(N_DIGITS)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [IDX_W-1:0] idx,
    output logic             slot_start,
    output logic             frame_end
);

    logic [CNT_W-1:0] cnt;
    logic             slot_end;
    logic             last_idx;

    assign slot_end   = (cnt == CNT_W'(PRESCALE - 1));
    assign last_idx   = (idx == IDX_W'(N_DIGITS - 1));
    assign slot_start = (cnt == '0);
    assign frame_end  = slot_end && last_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= last_idx ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Double-buffered N-digit scan multiplexer feeding one shared BCD-to-7-segment decoder.
// Optional blink support is compiled in when SEG_SCAN_BLINK_EN is defined.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int unsigned N_DIGITS   = 4,
    parameter int unsigned PRESCALE   = 50000,
    parameter int unsigned BLINK_FRMS = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [BCD_W*N_DIGITS-1:0] digits_in,
    input  logic [N_DIGITS-1:0]       dots_in,
    input  logic [N_DIGITS-1:0]       blank_in,
`ifdef SEG_SCAN_BLINK_EN
    input  logic [N_DIGITS-1:0]       blink_in,
`endif
    output logic [BCD_W-1:0]          num,
    output logic                      dot,
    output logic [N_DIGITS-1:0]       digit_sel
);

    localparam int unsigned IDX_W = $clog2(N_DIGITS);

    if (N_DIGITS < 2 || N_DIGITS > MAX_DIGITS || PRESCALE < 2 || BLINK_FRMS < 1) begin : g_bad_params
        $error("seg_scan_mux: parameter out of range");
    end

    logic [IDX_W-1:0] idx;
    logic             slot_start;
    logic             frame_end;

    seg_scan_tick #(
        .N_DIGITS (N_DIGITS),
        .PRESCALE (PRESCALE)
    ) u_tick (
        .clk        (clk),
        .rst        (rst),
        .idx        (idx),
        .slot_start (slot_start),
        .frame_end  (frame_end)
    );

    logic [BCD_W*N_DIGITS-1:0] pend_digits, act_digits;
    logic [N_DIGITS-1:0]       pend_dots,   act_dots;
    logic [N_DIGITS-1:0]       pend_blank,  act_blank;
    logic                      pending;

    // Commit first, capture second: a load on the boundary cycle lands in the
    // pending buffer after the old contents were committed, and stays pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_digits <= '0;
            act_digits  <= '0;
            pend_dots   <= '0;
            act_dots    <= '0;
            pend_blank  <= '1;
            act_blank   <= '1;
            pending     <= 1'b0;
        end else begin
            if (frame_end && pending) begin
                act_digits <= pend_digits;
                act_dots   <= pend_dots;
                act_blank  <= pend_blank;
                pending    <= 1'b0;
            end
            if (load) begin
                pend_digits <= digits_in;
                pend_dots   <= dots_in;
                pend_blank  <= blank_in;
                pending     <= 1'b1;
            end
        end
    end

`ifdef SEG_SCAN_BLINK_EN
    localparam int unsigned FRM_W = (BLINK_FRMS > 1) ? $clog2(BLINK_FRMS) : 1;

    logic [N_DIGITS-1:0] pend_blink, act_blink;
    logic [FRM_W-1:0]    frm_cnt;
    blink_phase_e        phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_blink <= '0;
            act_blink  <= '0;
            frm_cnt    <= '0;
            phase      <= BLINK_ON;
        end else begin
            if (frame_end && pending) begin
                act_blink <= pend_blink;
            end
            if (load) begin
                pend_blink <= blink_in;
            end
            if (frame_end) begin
                if (frm_cnt == FRM_W'(BLINK_FRMS - 1)) begin
                    frm_cnt <= '0;
                    phase   <= (phase == BLINK_ON) ? BLINK_OFF : BLINK_ON;
                end else begin
                    frm_cnt <= frm_cnt + 1'b1;
                end
            end
        end
    end
`endif

    logic                dark;
    logic [N_DIGITS-1:0] sel_next;

    always_comb begin
        dark = act_blank[idx];
`ifdef SEG_SCAN_BLINK_EN
        if (phase == BLINK_OFF && act_blink[idx]) begin
            dark = 1'b1;
        end
`endif
        sel_next = DIG_OFF[N_DIGITS-1:0];
        if (!slot_start && !dark) begin
            sel_next[idx] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            num       <= '0;
            dot       <= DP_OFF;
            digit_sel <= DIG_OFF[N_DIGITS-1:0];
        end else begin
            num       <= act_digits[{idx, 2'b00} +: BCD_W];
            dot       <= ~act_dots[idx];
            digit_sel <= sel_next;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux (default build, blink disabled).
module tb_seg_scan_mux;

    localparam int N     = 4;
    localparam int P     = 4;
    localparam int FRAME = N * P;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  dots_in = '0;
    logic [3:0]  blank_in = '0;
    logic [3:0]  num;
    logic        dot;
    logic [3:0]  digit_sel;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seg_scan_mux #(
        .N_DIGITS   (4),
        .PRESCALE   (4),
        .BLINK_FRMS (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .digits_in (digits_in),
        .dots_in   (dots_in),
        .blank_in  (blank_in),
        .num       (num),
        .dot       (dot),
        .digit_sel (digit_sel)
    );

    // Reference model: t = cycles since reset; slot and phase follow from plain arithmetic.
    int          t;
    bit          m_pend;
    logic [15:0] m_digits, p_digits;
    logic [3:0]  m_dots, p_dots, m_blank, p_blank;
    logic [3:0]  e_num;
    logic        e_dot;
    logic [3:0]  e_sel;

    task automatic model_step();
        int slot;
        int ph;
        if (rst) begin
            t = 0; m_pend = 0;
            m_digits = '0; p_digits = '0;
            m_dots = '0; p_dots = '0;
            m_blank = '1; p_blank = '1;
            e_num = 4'd0; e_dot = 1'b1; e_sel = 4'hF;
        end else begin
            slot  = (t / P) % N;
            ph    = t % P;
            e_num = m_digits[slot*4 +: 4];
            e_dot = !m_dots[slot];
            e_sel = 4'hF;
            if (ph != 0 && !m_blank[slot]) e_sel[slot] = 1'b0;
            if ((t % FRAME) == FRAME - 1 && m_pend) begin
                m_digits = p_digits; m_dots = p_dots; m_blank = p_blank; m_pend = 0;
            end
            if (load) begin
                p_digits = digits_in; p_dots = dots_in; p_blank = blank_in; m_pend = 1;
            end
            t++;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic pulse_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
        digits_in = d; dots_in = p; blank_in = b; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_phase(input int ph);
        for (int k = 0; k < 2 * FRAME; k++) begin
            if ((t % FRAME) == ph) break;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({num, dot, digit_sel} !== 9'b0000_1_1111) begin
            errors++;
            $display("FAIL reset_state: got num=%h dot=%b sel=%b want num=0 dot=1 sel=1111", num, dot, digit_sel);
        end
        rst = 1'b0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            checks++;
            if ({num, dot, digit_sel} !== 9'b0000_1_1111) begin
                errors++;
                $display("FAIL idle_after_reset cyc%0d: got num=%h dot=%b sel=%b want num=0 dot=1 sel=1111",
                         i, num, dot, digit_sel);
            end
        end
    endtask

    task automatic test_basic();
        int lit0;
        lit0 = 0;
        wait_phase(5);
        pulse_load(16'h1234, 4'b0001, 4'b0000);
        wait_phase(0);
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            checks++;
            if ({num, dot, digit_sel} !== {e_num, e_dot, e_sel}) begin
                errors++;
                $display("FAIL basic cyc%0d: got num=%h dot=%b sel=%b want num=%h dot=%b sel=%b",
                         i, num, dot, digit_sel, e_num, e_dot, e_sel);
            end
            if (digit_sel == 4'b1110 && num == 4'h4 && dot == 1'b0) lit0++;
        end
        checks++;
        if (lit0 !== 6) begin
            errors++;
            $display("FAIL basic_digit0_lit: got %0d cycles want 6", lit0);
        end
    endtask

    task automatic test_double_load();
        int ones;
        int fives;
        ones = 0; fives = 0;
        do_reset();
        wait_phase(2);
        pulse_load(16'h1111, 4'b0000, 4'b0000);
        wait_phase(8);
        pulse_load(16'h5678, 4'b0000, 4'b0000);
        wait_phase(0);
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            checks++;
            if ({num, dot, digit_sel} !== {e_num, e_dot, e_sel}) begin
                errors++;
                $display("FAIL double_load cyc%0d: got num=%h dot=%b sel=%b want num=%h dot=%b sel=%b",
                         i, num, dot, digit_sel, e_num, e_dot, e_sel);
            end
            if (num == 4'h1) ones++;
            if (num == 4'h5 && digit_sel == 4'b0111) fives++;
        end
        checks++;
        if (ones !== 0) begin
            errors++;
            $display("FAIL double_load_stale: got %0d cycles with num=1 want 0", ones);
        end
        checks++;
        if (fives !== 6) begin
            errors++;
            $display("FAIL double_load_new: got %0d cycles of digit3=5 want 6", fives);
        end
    endtask

    task automatic test_boundary_load();
        int seen_a;
        int seen_b;
        seen_a = 0; seen_b = 0;
        wait_phase(3);
        pulse_load(16'hFA90, 4'b0001, 4'b0000);
        wait_phase(15);
        pulse_load(16'h2468, 4'b0000, 4'b0000);
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            checks++;
            if ({num, dot, digit_sel} !== {e_num, e_dot, e_sel}) begin
                errors++;
                $display("FAIL boundary_load cyc%0d: got num=%h dot=%b sel=%b want num=%h dot=%b sel=%b",
                         i, num, dot, digit_sel, e_num, e_dot, e_sel);
            end
            if (i < FRAME && digit_sel == 4'b1110 && num == 4'h0 && dot == 1'b0) seen_a++;
            if (i >= FRAME && digit_sel == 4'b1110 && num == 4'h8 && dot == 1'b1) seen_b++;
        end
        checks++;
        if (seen_a !== 3) begin
            errors++;
            $display("FAIL boundary_old_frame: got %0d lit cycles want 3", seen_a);
        end
        checks++;
        if (seen_b !== 3) begin
            errors++;
            $display("FAIL boundary_new_frame: got %0d lit cycles want 3", seen_b);
        end
    endtask

    task automatic test_blank();
        int lit2;
        int lit0;
        lit2 = 0; lit0 = 0;
        wait_phase(6);
        pulse_load(16'($urandom), 4'($urandom), 4'b0100);
        wait_phase(0);
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            checks++;
            if ({num, dot, digit_sel} !== {e_num, e_dot, e_sel}) begin
                errors++;
                $display("FAIL blank cyc%0d: got num=%h dot=%b sel=%b want num=%h dot=%b sel=%b",
                         i, num, dot, digit_sel, e_num, e_dot, e_sel);
            end
            if (digit_sel == 4'b1011) lit2++;
            if (digit_sel == 4'b1110) lit0++;
        end
        checks++;
        if (lit2 !== 0 || lit0 !== 6) begin
            errors++;
            $display("FAIL blank_slots: got digit2 lit %0d digit0 lit %0d want 0 and 6", lit2, lit0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            checks++;
            if ({num, dot, digit_sel} !== {e_num, e_dot, e_sel}) begin
                errors++;
                $display("FAIL random cyc%0d: got num=%h dot=%b sel=%b want num=%h dot=%b sel=%b",
                         i, num, dot, digit_sel, e_num, e_dot, e_sel);
            end
            if ($urandom_range(7) == 0) begin
                digits_in = 16'($urandom);
                dots_in   = 4'($urandom);
                blank_in  = 4'($urandom);
                load      = 1'b1;
            end else begin
                load = 1'b0;
            end
        end
        load = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lit;
        lit = 0;
        wait_phase(6);
        pulse_load(16'h9999, 4'hF, 4'h0);
        wait_phase(10);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({num, dot, digit_sel} !== 9'b0000_1_1111) begin
            errors++;
            $display("FAIL reset_mid_state: got num=%h dot=%b sel=%b want num=0 dot=1 sel=1111", num, dot, digit_sel);
        end
        rst = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            checks++;
            if ({num, dot, digit_sel} !== {e_num, e_dot, e_sel}) begin
                errors++;
                $display("FAIL reset_mid_dark cyc%0d: got num=%h dot=%b sel=%b want num=%h dot=%b sel=%b",
                         i, num, dot, digit_sel, e_num, e_dot, e_sel);
            end
            if (digit_sel != 4'hF) lit++;
        end
        checks++;
        if (lit !== 0) begin
            errors++;
            $display("FAIL reset_mid_pending_dropped: got %0d lit cycles want 0", lit);
        end
        pulse_load(16'h1357, 4'b1000, 4'b0000);
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            checks++;
            if ({num, dot, digit_sel} !== {e_num, e_dot, e_sel}) begin
                errors++;
                $display("FAIL reset_mid_restart cyc%0d: got num=%h dot=%b sel=%b want num=%h dot=%b sel=%b",
                         i, num, dot, digit_sel, e_num, e_dot, e_sel);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_double_load();
        test_boundary_load();
        test_blank();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
